// File: rtl/cursor_blink_draw.sv
// cursor_blink_draw
//   Draws and erases a blinking cursor in the paint framebuffer. Each blink tick
//   (rising edge of CB) either shows the cursor (read the pixel under it, then
//   write the cursor colour) or hides it (write the saved pixel back). A cursor
//   move while shown restores the old pixel and redraws at the new position.
//   The block also keeps the blink timer running while it is enabled.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   init           enable (level)
//   hold           1 = painter owns memory, no new transactions from WAIT
//   CB             blink tick from timer (pulse, edge-detected here)
//   cursor_x/y     cursor position; cursor_color = colour drawn for the cursor
//   tmr_init/rst   control of the blink timer FSM
//   mem_*          framebuffer request/ack port, address = {y, x}
//   visible        cursor currently present in the framebuffer
//   busy           memory transaction in progress
module cursor_blink_draw #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int COLOR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic                 hold,
    input  logic                 CB,
    input  logic [X_W-1:0]       cursor_x,
    input  logic [Y_W-1:0]       cursor_y,
    input  logic [COLOR_W-1:0]   cursor_color,
    output logic                 tmr_init,
    output logic                 tmr_rst,
    output logic [X_W+Y_W-1:0]   mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [COLOR_W-1:0]   mem_wdata,
    input  logic [COLOR_W-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic                 visible,
    output logic                 busy
);

    localparam int A_W = X_W + Y_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        SHOW_RD = 3'd2,
        SHOW_WR = 3'd3,
        HIDE_WR = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 cb_q, cb_d;
    logic                 pending_q, pending_d;
    logic [A_W-1:0]       pos_q, pos_d;
    logic [COLOR_W-1:0]   saved_q, saved_d;
    logic                 exit_q, exit_d;
    logic                 move_q, move_d;
    logic                 visible_q, visible_d;
    logic                 tmr_init_q, tmr_init_d;
    logic                 tmr_rst_q, tmr_rst_d;
    logic [A_W-1:0]       mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [COLOR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;

    logic                 tick;
    logic                 tick_used;
    logic [A_W-1:0]       cur_pos;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pos_d       = pos_q;
        saved_d     = saved_q;
        exit_d      = exit_q;
        move_d      = move_q;
        visible_d   = visible_q;
        tick_used   = 1'b0;

        cb_d    = CB;
        tick    = CB & ~cb_q;
        cur_pos = {cursor_y, cursor_x};

        case (state_q)
            IDLE: begin
                if (init) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Rules are prioritised: disable, then move, then blink.
                if (!hold) begin
                    if (!init) begin
                        if (visible_q) begin
                            state_d = HIDE_WR;
                            exit_d  = 1'b1;
                            move_d  = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (visible_q && (cur_pos != pos_q)) begin
                        state_d = HIDE_WR;
                        exit_d  = 1'b0;
                        move_d  = 1'b1;
                    end else if (tick || pending_q) begin
                        tick_used = 1'b1;
                        pending_d = 1'b0;
                        if (visible_q) begin
                            state_d = HIDE_WR;
                            exit_d  = 1'b0;
                            move_d  = 1'b0;
                        end else begin
                            state_d = SHOW_RD;
                            pos_d   = cur_pos;
                        end
                    end
                end
            end
            SHOW_RD: begin
                if (mem_ack) begin
                    saved_d = mem_rdata;
                    state_d = SHOW_WR;
                end
            end
            SHOW_WR: begin
                if (mem_ack) begin
                    visible_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            HIDE_WR: begin
                if (mem_ack) begin
                    visible_d = 1'b0;
                    if (exit_q) begin
                        state_d = IDLE;
                    end else if (move_q) begin
                        // Redraw immediately at the new position.
                        state_d = SHOW_RD;
                        pos_d   = cur_pos;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick not consumed this cycle is remembered once; extra ticks drop.
        if (tick && !tick_used) begin
            pending_d = 1'b1;
        end

        // Outputs are registered from the next state so they are glitch-free
        // and line up with the state they describe.
        tmr_rst_d  = (state_d == IDLE);
        tmr_init_d = (state_d != IDLE);
        mem_rd_d   = (state_d == SHOW_RD);
        mem_wr_d   = (state_d == SHOW_WR) || (state_d == HIDE_WR);
        busy_d     = mem_rd_d || mem_wr_d;
        mem_addr_d = pos_d;

        mem_wdata_d = '0;
        if (state_d == SHOW_WR) begin
            // Colour is captured on entry and held for the whole request.
            mem_wdata_d = (state_q == SHOW_WR) ? mem_wdata_q : cursor_color;
        end else if (state_d == HIDE_WR) begin
            mem_wdata_d = saved_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cb_q        <= 1'b0;
            pending_q   <= 1'b0;
            pos_q       <= '0;
            saved_q     <= '0;
            exit_q      <= 1'b0;
            move_q      <= 1'b0;
            visible_q   <= 1'b0;
            tmr_init_q  <= 1'b0;
            tmr_rst_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cb_q        <= cb_d;
            pending_q   <= pending_d;
            pos_q       <= pos_d;
            saved_q     <= saved_d;
            exit_q      <= exit_d;
            move_q      <= move_d;
            visible_q   <= visible_d;
            tmr_init_q  <= tmr_init_d;
            tmr_rst_q   <= tmr_rst_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign tmr_init  = tmr_init_q;
    assign tmr_rst   = tmr_rst_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign visible   = visible_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cursor_blink_draw.sv
module tb_cursor_blink_draw;

    localparam int X_W = 6;
    localparam int Y_W = 6;
    localparam int C_W = 3;
    localparam int A_W = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           init = 1'b0;
    logic           hold = 1'b0;
    logic           CB = 1'b0;
    logic [X_W-1:0] cursor_x = '0;
    logic [Y_W-1:0] cursor_y = '0;
    logic [C_W-1:0] cursor_color = '0;
    logic           tmr_init, tmr_rst;
    logic [A_W-1:0] mem_addr;
    logic           mem_rd, mem_wr;
    logic [C_W-1:0] mem_wdata;
    logic [C_W-1:0] mem_rdata = '0;
    logic           mem_ack = 1'b0;
    logic           visible, busy;

    cursor_blink_draw #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(C_W)) dut (
        .clk(clk), .rst(rst), .init(init), .hold(hold), .CB(CB),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_color(cursor_color),
        .tmr_init(tmr_init), .tmr_rst(tmr_rst), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .visible(visible), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           wr;
        logic [A_W-1:0] addr;
        logic [C_W-1:0] data;
    } txn_t;

    txn_t           exp_q[$];
    logic [C_W-1:0] fb     [4096];   // framebuffer seen by the DUT
    logic [C_W-1:0] ref_fb [4096];   // what the framebuffer should contain
    int             n_cmp = 0;
    int             n_bad = 0;
    int             lat = 2;
    bit             ign = 1'b0;

    // Reference model state: is the cursor drawn, where, and what it covers.
    bit             m_vis = 1'b0;
    logic [A_W-1:0] m_pos = '0;
    logic [C_W-1:0] m_saved = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic txn_t mk(input logic w, input logic [A_W-1:0] a, input logic [C_W-1:0] d);
        txn_t t;
        t.wr = w; t.addr = a; t.data = d;
        return t;
    endfunction

    // Drawing the cursor: read what is underneath, then paint the colour.
    task automatic exp_show();
        m_pos   = {cursor_y, cursor_x};
        m_saved = ref_fb[m_pos];
        exp_q.push_back(mk(1'b0, m_pos, '0));
        exp_q.push_back(mk(1'b1, m_pos, cursor_color));
        ref_fb[m_pos] = cursor_color;
        m_vis = 1'b1;
    endtask

    // Erasing the cursor: put the covered pixel back.
    task automatic exp_hide();
        exp_q.push_back(mk(1'b1, m_pos, m_saved));
        ref_fb[m_pos] = m_saved;
        m_vis = 1'b0;
    endtask

    task automatic exp_tick();
        if (m_vis) exp_hide();
        else exp_show();
    endtask

    task automatic pulse_cb(input int len);
        @(negedge clk);
        CB = 1'b1;
        repeat (len) @(negedge clk);
        CB = 1'b0;
    endtask

    // Wait for three consecutive idle cycles, then require every expected
    // transaction to have been seen.
    task automatic settle();
        int t = 0;
        int quiet = 0;
        while (quiet < 3 && t < 600) begin
            @(negedge clk);
            t++;
            if (busy) quiet = 0;
            else quiet++;
        end
        if (quiet < 3) begin
            n_cmp++; n_bad++;
            $display("FAIL settle_timeout: busy still %0b after %0d cycles", busy, t);
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Framebuffer memory: acks each request 'lat' cycles after it appears.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = C_W'($urandom);
            if (!rst && (mem_rd || mem_wr)) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    if (mem_rd) mem_rdata = fb[mem_addr];
                    else fb[mem_addr] = mem_wdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every completed handshake is matched against the scoreboard.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !ign && (mem_rd || mem_wr)) begin
                n_cmp++;
                if (mem_rd && mem_wr) begin
                    n_bad++;
                    $display("FAIL rd_wr_overlap: rd=%0b wr=%0b required not both", mem_rd, mem_wr);
                end
                if (mem_ack) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_txn: wr=%0b addr=%0h data=%0h, none expected",
                                 mem_wr, mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.wr !== mem_wr || e.addr !== mem_addr || (e.wr && e.data !== mem_wdata)) begin
                            n_bad++;
                            $display("FAIL txn: got wr=%0b addr=%0h data=%0h expected wr=%0b addr=%0h data=%0h",
                                     mem_wr, mem_addr, mem_wdata, e.wr, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int op;
        int t;
        int diff;
        logic [A_W-1:0] np;

        for (int i = 0; i < 4096; i++) begin
            fb[i] = C_W'($urandom);
            ref_fb[i] = fb[i];
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tmr_rst", tmr_rst, 1);
        check("rst_tmr_init", tmr_init, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_visible", visible, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tmr_rst", tmr_rst, 1);

        // T1: show at (3,5) over pixel 010 with colour 111.
        fb[12'h143] = 3'b010; ref_fb[12'h143] = 3'b010;
        cursor_x = 6'd3; cursor_y = 6'd5; cursor_color = 3'b111; lat = 2;
        init = 1'b1;
        repeat (2) @(negedge clk);
        check("wait_tmr_init", tmr_init, 1);
        check("wait_tmr_rst", tmr_rst, 0);
        exp_show();
        pulse_cb(25);
        settle();
        check("t1_visible", visible, 1);
        check("t1_pixel", fb[12'h143], 3'b111);

        // T2: next pulse restores 010.
        exp_tick();
        pulse_cb(25);
        settle();
        check("t2_visible", visible, 0);
        check("t2_pixel", fb[12'h143], 3'b010);

        // T3: show, then move to (4,5).
        exp_tick();
        pulse_cb(25);
        settle();
        cursor_x = 6'd4;
        exp_hide();
        exp_show();
        settle();
        check("t3_visible", visible, 1);
        check("t3_addr", m_pos, 12'h144);

        // T4: disable while visible.
        init = 1'b0;
        exp_hide();
        settle();
        check("t4_tmr_rst", tmr_rst, 1);
        check("t4_tmr_init", tmr_init, 0);
        check("t4_visible", visible, 0);
        init = 1'b1;
        settle();

        // T5a: hold blocks the start; pending tick serviced on release.
        hold = 1'b1;
        pulse_cb(5);
        repeat (4) @(negedge clk);
        check("t5_hold_busy", busy, 0);
        exp_tick();
        hold = 1'b0;
        settle();
        check("t5_hold_visible", visible, m_vis);
        exp_tick();
        pulse_cb(3);
        settle();

        // T5b: tick during SHOW_WR becomes a pending hide.
        exp_show();
        exp_hide();
        pulse_cb(1);
        t = 0;
        while (!mem_wr && t < 50) begin @(negedge clk); t++; end
        check("t5_saw_show_wr", mem_wr, 1);
        CB = 1'b1;
        @(negedge clk);
        CB = 1'b0;
        settle();
        check("t5_pending_visible", visible, 0);

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            lat = $urandom_range(1, 4);
            op  = $urandom_range(0, 5);
            if (!m_vis) cursor_color = C_W'($urandom);
            case (op)
                0, 1: begin
                    if (!m_vis && $urandom_range(0, 1) == 1) begin
                        cursor_x = X_W'($urandom);
                        cursor_y = Y_W'($urandom);
                    end
                    exp_tick();
                    pulse_cb($urandom_range(1, 30));
                    settle();
                end
                2: begin
                    np = A_W'($urandom);
                    if (np == m_pos) np = np + 1'b1;
                    cursor_x = np[X_W-1:0];
                    cursor_y = np[A_W-1:X_W];
                    if (m_vis) begin
                        exp_hide();
                        exp_show();
                    end
                    settle();
                end
                3: begin
                    init = 1'b0;
                    if (m_vis) exp_hide();
                    settle();
                    check("rnd_off_tmr_rst", tmr_rst, 1);
                    check("rnd_off_tmr_init", tmr_init, 0);
                    init = 1'b1;
                    settle();
                    check("rnd_on_tmr_init", tmr_init, 1);
                end
                4: begin
                    hold = 1'b1;
                    pulse_cb($urandom_range(1, 10));
                    repeat (3) @(negedge clk);
                    check("rnd_hold_busy", busy, 0);
                    exp_tick();
                    hold = 1'b0;
                    settle();
                end
                default: begin
                    if (!m_vis) begin
                        exp_show();
                        exp_hide();
                        pulse_cb(1);
                        t = 0;
                        while (!mem_wr && t < 50) begin @(negedge clk); t++; end
                        check("rnd_saw_show_wr", mem_wr, 1);
                        CB = 1'b1;
                        @(negedge clk);
                        CB = 1'b0;
                    end else begin
                        exp_tick();
                        pulse_cb(1);
                    end
                    settle();
                end
            endcase
            check("rnd_visible", visible, m_vis);
        end

        diff = 0;
        for (int i = 0; i < 4096; i++) if (fb[i] !== ref_fb[i]) diff++;
        check("fb_image_diffs", diff, 0);

        // T6: reset in the middle of a read.
        if (m_vis) begin
            exp_tick();
            pulse_cb(2);
            settle();
        end
        lat = 3;
        ign = 1'b1;
        pulse_cb(1);
        t = 0;
        while (!mem_rd && t < 50) begin @(negedge clk); t++; end
        check("t6_saw_rd", mem_rd, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_mem_rd", mem_rd, 0);
        check("t6_visible", visible, 0);
        check("t6_busy", busy, 0);
        check("t6_tmr_rst", tmr_rst, 1);
        check("t6_tmr_init", tmr_init, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
